// File: rtl/trace_pkg.sv
// Shared branch-trace definitions used by both the trace encoder and the ROP detector:
// event kinds, trampoline slot geometry and the encode/classify helpers.
package trace_pkg;

    typedef enum logic [1:0] {
        EVT_JUMP = 2'b00,
        EVT_CALL = 2'b01,
        EVT_RET  = 2'b10,
        EVT_RSVD = 2'b11
    } evt_type_e;

    localparam int unsigned TRAMPOLINE_FUNCTION_GAP = 8;
    localparam int unsigned RETURN_OFFSET           = 4;

    // Slot address carried in 33 bits so a wrap past 2^32 appears in bit 32.
    function automatic logic [32:0] slot_addr(input logic [31:0] start,
                                              input logic [31:0] k,
                                              input logic        isRet);
        logic [32:0] base;
        base = {1'b0, start} + ({1'b0, k} - 33'd1) * 33'(TRAMPOLINE_FUNCTION_GAP);
        return isRet ? base + 33'(RETURN_OFFSET) : base;
    endfunction

    function automatic logic [31:0] encode_event(input evt_type_e  evtType,
                                                 input logic [31:0] k,
                                                 input logic [31:0] target,
                                                 input logic [31:0] start);
        logic [32:0] addr;
        addr = slot_addr(start, k, evtType == EVT_RET);
        return (evtType == EVT_JUMP) ? target : addr[31:0];
    endfunction

    function automatic logic evt_legal(input evt_type_e  evtType,
                                       input logic [31:0] k,
                                       input logic [31:0] target,
                                       input logic [31:0] start,
                                       input logic [31:0] last);
        logic [32:0] addr;
        logic        legal;
        addr = slot_addr(start, k, evtType == EVT_RET);
        case (evtType)
            EVT_JUMP: legal = (target < start) || (target > last);
            EVT_CALL,
            EVT_RET:  legal = (k != 32'd0) && !addr[32] && (addr[31:0] <= last);
            default:  legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/trace_evt_buf.sv
// Circular event buffer with read/write pointers and an occupancy counter;
// a push and a pop in the same cycle are allowed even when the buffer is full.
module trace_evt_buf #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [WIDTH-1:0]             data_i,
    output logic [WIDTH-1:0]             data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic                         full_next_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pushOk, popOk;

    always_comb begin
        popOk  = pop_i && (cnt_q != '0);
        pushOk = push_i && ((cnt_q != CW'(DEPTH)) || popOk);
        rd_d   = popOk  ? rd_q + AW'(1) : rd_q;
        wr_d   = pushOk ? wr_q + AW'(1) : wr_q;
        cnt_d  = cnt_q + CW'(pushOk) - CW'(popOk);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (pushOk) begin
            mem_q[wr_q] <= data_i;
        end
    end

    assign data_o      = mem_q[rd_q];
    assign full_o      = (cnt_q == CW'(DEPTH));
    assign empty_o     = (cnt_q == '0);
    assign full_next_o = (cnt_d == CW'(DEPTH));
    assign count_o     = cnt_q;

endmodule

// File: rtl/trace_encoder.sv
// Encodes call/return/jump events as trampoline addresses and streams them into the trace FIFO.
// Optional TRACE_JUMP_FILTER_EN: legal jumps are accepted but never written to the FIFO.
module trace_encoder #(
    parameter int BUF_DEPTH = 4,
    parameter int FUNC_W    = 6,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic [31:0]          iTRAMPOLINE_START,
    input  logic [31:0]          iTRAMPOLINE_END,
    input  logic                 iEvt_Valid,
    input  logic [1:0]           iEvt_Type,
    input  logic [FUNC_W-1:0]    iEvt_Func,
    input  logic [31:0]          iEvt_Target,
    output logic                 oEvt_Ready,
    input  logic                 iFifo_Full,
    output logic                 oFifo_WrEn,
    output logic [31:0]          oFifo_Data,
    output logic                 oEncErr,
    output logic [ERR_CNT_W-1:0] oErrCnt
);

    import trace_pkg::*;

    evt_type_e              evtType;
    logic [31:0]            encWord;
    logic                   evtLegal, keepEvt, accept, wantWrite;
    logic                   fifoWr, stageFree, bypass, bufPush, bufPop;
    logic                   bufEmpty, bufFull, bufFullNext;
    logic [31:0]            bufHead;
    logic [$clog2(BUF_DEPTH+1)-1:0] bufCount;
    logic                   unusedBufStatus;

    logic                   ready_q, err_q;
    logic                   outValid_q, outValid_d;
    logic [31:0]            outData_q, outData_d;
    logic [ERR_CNT_W-1:0]   errCnt_q, errCnt_d;

`ifdef TRACE_JUMP_FILTER_EN
    assign keepEvt = (evtType != EVT_JUMP);
`else
    assign keepEvt = 1'b1;
`endif

    always_comb begin
        evtType  = evt_type_e'(iEvt_Type);
        encWord  = encode_event(evtType, 32'(iEvt_Func), iEvt_Target, iTRAMPOLINE_START);
        evtLegal = evt_legal(evtType, 32'(iEvt_Func), iEvt_Target,
                             iTRAMPOLINE_START, iTRAMPOLINE_END);
    end

    // The stage takes the buffer head first; the bypass only applies when nothing is queued ahead.
    always_comb begin
        accept    = iEvt_Valid && ready_q;
        wantWrite = accept && evtLegal && keepEvt;
        fifoWr    = outValid_q && !iFifo_Full;
        stageFree = !outValid_q || fifoWr;
        bufPop    = stageFree && !bufEmpty;
        bypass    = wantWrite && bufEmpty && stageFree;
        bufPush   = wantWrite && !bypass;

        outValid_d = outValid_q;
        outData_d  = outData_q;
        if (bufPop) begin
            outValid_d = 1'b1;
            outData_d  = bufHead;
        end else if (bypass) begin
            outValid_d = 1'b1;
            outData_d  = encWord;
        end else if (fifoWr) begin
            outValid_d = 1'b0;
        end

        errCnt_d = errCnt_q;
        if (accept && !evtLegal && (errCnt_q != '1)) begin
            errCnt_d = errCnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            errCnt_q   <= '0;
        end else begin
            ready_q    <= !bufFullNext;
            err_q      <= accept && !evtLegal;
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            errCnt_q   <= errCnt_d;
        end
    end

    trace_evt_buf #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (32)
    ) u_evt_buf (
        .clk_i       (iClk),
        .rst_i       (iRst),
        .push_i      (bufPush),
        .pop_i       (bufPop),
        .data_i      (encWord),
        .data_o      (bufHead),
        .full_o      (bufFull),
        .empty_o     (bufEmpty),
        .full_next_o (bufFullNext),
        .count_o     (bufCount)
    );

    assign unusedBufStatus = ^{bufFull, bufCount};

    assign oEvt_Ready = ready_q;
    assign oFifo_WrEn = fifoWr;
    assign oFifo_Data = outData_q;
    assign oEncErr    = err_q;
    assign oErrCnt    = errCnt_q;

endmodule

// File: tb/tb_trace_encoder.sv
// Directed bench for trace_encoder with START=0x1000, END=0x10FF; inputs change 1 time unit
// after the rising edge and outputs are checked there.
module tb_trace_encoder;

    logic        iClk;
    logic        iRst;
    logic [31:0] iTRAMPOLINE_START;
    logic [31:0] iTRAMPOLINE_END;
    logic        iEvt_Valid;
    logic [1:0]  iEvt_Type;
    logic [5:0]  iEvt_Func;
    logic [31:0] iEvt_Target;
    logic        oEvt_Ready;
    logic        iFifo_Full;
    logic        oFifo_WrEn;
    logic [31:0] oFifo_Data;
    logic        oEncErr;
    logic [15:0] oErrCnt;

    int          testsRun  = 0;
    int          failCount = 0;
    int unsigned pulseCount = 0;
    int unsigned pulseBase;

    localparam logic [1:0] T_JUMP = 2'b00;
    localparam logic [1:0] T_CALL = 2'b01;
    localparam logic [1:0] T_RET  = 2'b10;
    localparam logic [1:0] T_RSVD = 2'b11;

    logic [31:0] expWords [6] = '{32'h1000, 32'h1008, 32'h1010, 32'h1018, 32'h1020, 32'h1028};

    trace_encoder #(
        .BUF_DEPTH (4),
        .FUNC_W    (6),
        .ERR_CNT_W (16)
    ) dut (
        .iClk              (iClk),
        .iRst              (iRst),
        .iTRAMPOLINE_START (iTRAMPOLINE_START),
        .iTRAMPOLINE_END   (iTRAMPOLINE_END),
        .iEvt_Valid        (iEvt_Valid),
        .iEvt_Type         (iEvt_Type),
        .iEvt_Func         (iEvt_Func),
        .iEvt_Target       (iEvt_Target),
        .oEvt_Ready        (oEvt_Ready),
        .iFifo_Full        (iFifo_Full),
        .oFifo_WrEn        (oFifo_WrEn),
        .oFifo_Data        (oFifo_Data),
        .oEncErr           (oEncErr),
        .oErrCnt           (oErrCnt)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Counts every cycle in which the error pulse is high.
    always @(negedge iClk) begin
        if (oEncErr) pulseCount <= pulseCount + 1;
    end

    task automatic stepCycle();
        @(posedge iClk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [1:0] evtType,
                                 input logic [5:0] func, input logic [31:0] target);
        iEvt_Valid  = valid;
        iEvt_Type   = evtType;
        iEvt_Func   = func;
        iEvt_Target = target;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        iRst              = 1'b1;
        iTRAMPOLINE_START = 32'h0000_1000;
        iTRAMPOLINE_END   = 32'h0000_10FF;
        iFifo_Full        = 1'b0;
        applyStimulus(1'b0, T_JUMP, 6'd0, 32'h0);
        stepCycle();
        stepCycle();

        checkOutput("reset_wren",   32'(oFifo_WrEn), 32'd0);
        checkOutput("reset_data",   oFifo_Data,      32'd0);
        checkOutput("reset_ready",  32'(oEvt_Ready), 32'd0);
        checkOutput("reset_encerr", 32'(oEncErr),    32'd0);
        checkOutput("reset_errcnt", 32'(oErrCnt),    32'd0);
        iRst = 1'b0;
        stepCycle();
        checkOutput("ready_after_reset", 32'(oEvt_Ready), 32'd1);

        // call 3 then return 3
        applyStimulus(1'b1, T_CALL, 6'd3, 32'h0);
        stepCycle();
        applyStimulus(1'b1, T_RET, 6'd3, 32'h0);
        checkOutput("call3_wren", 32'(oFifo_WrEn), 32'd1);
        checkOutput("call3_data", oFifo_Data,      32'h1010);
        stepCycle();
        applyStimulus(1'b0, T_JUMP, 6'd0, 32'h0);
        checkOutput("ret3_wren", 32'(oFifo_WrEn), 32'd1);
        checkOutput("ret3_data", oFifo_Data,      32'h1014);
        stepCycle();
        checkOutput("idle_wren", 32'(oFifo_WrEn), 32'd0);

        // legal jump then aliasing jump
        applyStimulus(1'b1, T_JUMP, 6'd0, 32'h2000);
        stepCycle();
        applyStimulus(1'b1, T_JUMP, 6'd0, 32'h1008);
`ifdef TRACE_JUMP_FILTER_EN
        checkOutput("jump_filtered_wren", 32'(oFifo_WrEn), 32'd0);
`else
        checkOutput("jump_wren", 32'(oFifo_WrEn), 32'd1);
        checkOutput("jump_data", oFifo_Data,      32'h2000);
`endif
        checkOutput("jump_no_err", 32'(oEncErr), 32'd0);
        stepCycle();
        applyStimulus(1'b0, T_JUMP, 6'd0, 32'h0);
        checkOutput("alias_jump_err",    32'(oEncErr),    32'd1);
        checkOutput("alias_jump_errcnt", 32'(oErrCnt),    32'd1);
        checkOutput("alias_jump_wren",   32'(oFifo_WrEn), 32'd0);
        stepCycle();
        checkOutput("err_pulse_ends", 32'(oEncErr), 32'd0);

        // slot boundary: k=32 legal, k=33 past END, k=0 illegal, return k=32 legal (errors accumulate)
        applyStimulus(1'b1, T_CALL, 6'd32, 32'h0);
        stepCycle();
        applyStimulus(1'b1, T_CALL, 6'd33, 32'h0);
        checkOutput("call32_wren", 32'(oFifo_WrEn), 32'd1);
        checkOutput("call32_data", oFifo_Data,      32'h10F8);
        stepCycle();
        applyStimulus(1'b1, T_CALL, 6'd0, 32'h0);
        checkOutput("call33_err",    32'(oEncErr),    32'd1);
        checkOutput("call33_errcnt", 32'(oErrCnt),    32'd2);
        checkOutput("call33_wren",   32'(oFifo_WrEn), 32'd0);
        stepCycle();
        applyStimulus(1'b1, T_RET, 6'd32, 32'h0);
        checkOutput("call0_err",    32'(oEncErr), 32'd1);
        checkOutput("call0_errcnt", 32'(oErrCnt), 32'd3);
        stepCycle();
        applyStimulus(1'b0, T_JUMP, 6'd0, 32'h0);
        checkOutput("ret32_wren", 32'(oFifo_WrEn), 32'd1);
        checkOutput("ret32_data", oFifo_Data,      32'h10FC);
        checkOutput("ret32_err",  32'(oEncErr),    32'd0);
        stepCycle();

        // back-pressure: calls 1..5 accepted, call 6 held off
        iFifo_Full = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b1, T_CALL, 6'(k), 32'h0);
            checkOutput("bp_ready_high", 32'(oEvt_Ready), 32'd1);
            stepCycle();
            checkOutput("bp_wren_held", 32'(oFifo_WrEn), 32'd0);
        end
        applyStimulus(1'b1, T_CALL, 6'd6, 32'h0);
        checkOutput("bp_ready_low", 32'(oEvt_Ready), 32'd0);
        stepCycle();
        checkOutput("bp_ready_still_low", 32'(oEvt_Ready), 32'd0);
        checkOutput("bp_stage_data",      oFifo_Data,      32'h1000);
        iFifo_Full = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) begin
            checkOutput("drain_wren", 32'(oFifo_WrEn), 32'd1);
            checkOutput("drain_data", oFifo_Data,      expWords[i]);
            if (i == 1) checkOutput("drain_ready_back", 32'(oEvt_Ready), 32'd1);
            stepCycle();
            if (i == 1) applyStimulus(1'b0, T_JUMP, 6'd0, 32'h0);
        end
        checkOutput("drain_done_wren", 32'(oFifo_WrEn), 32'd0);

        // reset with three words pending
        iFifo_Full = 1'b1;
        applyStimulus(1'b1, T_CALL, 6'd7, 32'h0);
        stepCycle();
        applyStimulus(1'b1, T_CALL, 6'd8, 32'h0);
        stepCycle();
        applyStimulus(1'b1, T_CALL, 6'd9, 32'h0);
        stepCycle();
        applyStimulus(1'b0, T_JUMP, 6'd0, 32'h0);
        iFifo_Full = 1'b0;
        #1;
        checkOutput("pending_wren", 32'(oFifo_WrEn), 32'd1);
        checkOutput("pending_data", oFifo_Data,      32'h1030);
        iRst = 1'b1;
        #1;
        checkOutput("midrst_wren",  32'(oFifo_WrEn), 32'd0);
        checkOutput("midrst_ready", 32'(oEvt_Ready), 32'd0);
        checkOutput("midrst_data",  oFifo_Data,      32'd0);
        stepCycle();
        iRst = 1'b0;
        checkOutput("rel_ready_low", 32'(oEvt_Ready), 32'd0);
        stepCycle();
        checkOutput("rel_ready_high", 32'(oEvt_Ready), 32'd1);
        checkOutput("rel_wren_a",     32'(oFifo_WrEn), 32'd0);
        stepCycle();
        checkOutput("rel_wren_b",   32'(oFifo_WrEn), 32'd0);
        checkOutput("rel_errcnt",   32'(oErrCnt),    32'd0);

        // error counter saturation with 65538 reserved-type events
        pulseBase = pulseCount;
        applyStimulus(1'b1, T_RSVD, 6'd1, 32'h0);
        repeat (65534) stepCycle();
        checkOutput("sat_errcnt_fffe", 32'(oErrCnt), 32'h0000_FFFE);
        stepCycle();
        checkOutput("sat_errcnt_ffff", 32'(oErrCnt), 32'h0000_FFFF);
        checkOutput("sat_pulse_a",     32'(oEncErr), 32'd1);
        repeat (3) stepCycle();
        applyStimulus(1'b0, T_JUMP, 6'd0, 32'h0);
        checkOutput("sat_errcnt_hold", 32'(oErrCnt), 32'h0000_FFFF);
        checkOutput("sat_pulse_b",     32'(oEncErr), 32'd1);
        stepCycle();
        checkOutput("sat_pulse_count", pulseCount - pulseBase, 32'd65538);
        checkOutput("sat_pulse_ends",  32'(oEncErr),           32'd0);
        checkOutput("sat_ready",       32'(oEvt_Ready),        32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/trace_encoder.md
Name: trace_encoder

Overview:
- Branch-trace producer; the write-side counterpart of the ROP detector.
- Accepts call/return/jump events from the CPU-side monitor and encodes each as one 32-bit trampoline address.
  - Call k is encoded as the function entry slot.
  - Return k is encoded as the entry slot plus a fixed offset.
  - A jump is encoded as its raw target address.
- Pushes encoded words into the trace FIFO through a small internal buffer with full back-pressure handling.

Parameters:
- TRAMPOLINE_FUNCTION_GAP, 8: byte distance between consecutive function slots; power of two, at least 2.
- RETURN_OFFSET, 4: offset of the return address inside a slot; range 1..GAP-1.
- BUF_DEPTH, 4: internal event buffer entries; power of two.
- FUNC_W, 6: width of the function index.
- ERR_CNT_W, 16: width of the error counter.

Ports:
- iClk  in  1  clock.
- iRst  in  1  reset; asynchronous, active-high.
- iTRAMPOLINE_START  in  32  first trampoline byte address; quasi-static.
- iTRAMPOLINE_END  in  32  last trampoline byte address, inclusive; quasi-static.
- iEvt_Valid  in  1  event present.
- iEvt_Type  in  2  event kind: 00 jump, 01 call, 10 return, 11 reserved.
- iEvt_Func  in  FUNC_W  function index k; 1-based; used for call and return.
- iEvt_Target  in  32  jump target; used for jump only.
- oEvt_Ready  out  1  encoder can accept an event this cycle.
- iFifo_Full  in  1  trace FIFO full.
- oFifo_WrEn  out  1  write strobe.
- oFifo_Data  out  32  encoded word.
- oEncErr  out  1  one-cycle pulse for an illegal event.
- oErrCnt  out  ERR_CNT_W  saturating count of illegal events.

Behaviour:
- Reset: all outputs 0, buffer empty, output stage empty, counter 0. Reset asserted mid-operation discards all buffered and staged words immediately.
- Accept: an event is taken on a rising edge when iEvt_Valid && oEvt_Ready.
  - oEvt_Ready = !buf_full, and is registered.
  - Behaviour when Valid is high and Ready is low: the event is not taken; the source must hold it.
- Encoding, in 32-bit unsigned arithmetic:
  - call k: START + (k-1)*GAP
  - return k: START + (k-1)*GAP + RETURN_OFFSET
  - jump: iEvt_Target
- Illegal events. Each is dropped (not buffered); oEncErr pulses the cycle after acceptance; oErrCnt increments and saturates at all-ones.
  - k == 0.
  - Encoded call/return address > END, or the sum wraps past 2^32.
  - Jump target inside [START, END], which would alias as a call or return.
  - Type 11.
- Buffer: circular, BUF_DEPTH entries, with rd/wr pointers plus an occupancy counter.
  - An accept and a dequeue in the same cycle leave occupancy unchanged; this is legal when the buffer is full.
  - buf_full is computed from next-state occupancy, so Ready deasserts the cycle the last slot fills.
- Output stage: one register holding out_valid and out_data.
  - oFifo_WrEn = out_valid && !iFifo_Full (combinational); oFifo_Data = out_data.
  - The stage reloads from the buffer head when it is empty or being written this cycle.
  - A buffer-empty bypass loads the encoded event directly into the stage.
- Latency: event accepted at edge N gives oFifo_WrEn high from edge N+1, if the FIFO is not full.
- Ordering: words leave in acceptance order; no reordering or merging.
- Back-pressure: while iFifo_Full is high, the stage holds; the buffer fills to BUF_DEPTH, then Ready drops. No word is ever lost or duplicated.
- Sustained throughput: one word per clock when not full.
- Simultaneous illegal event and counter saturation: the pulse still fires and the counter holds.

Optional Feature:
- Macro: TRACE_JUMP_FILTER_EN.
- Defined: legal jump events are accepted (Ready honoured) but discarded without writing the FIFO. The detector ignores jumps, so this saves FIFO bandwidth. Illegal in-range jumps still raise oEncErr.
- Undefined: legal jumps are encoded and written as above.

Decomposition:
- Shared package trace_pkg, also used by the detector side:
  - event-type constants EVT_JUMP, EVT_CALL, EVT_RET
  - TRAMPOLINE_FUNCTION_GAP
  - RETURN_OFFSET
  - encode/classify helper functions
- One natural sub-module: trace_evt_buf, the parameterised circular buffer with push/pop/full/empty/occupancy.

Test Plan:
- Test parameters: START=0x1000, END=0x10FF.
- Call k=3, then return k=3, FIFO not full -> FIFO gets 0x1010 then 0x1014 on consecutive cycles; first WrEn one cycle after accept.
- Jump to 0x2000, then jump to 0x1008 -> 0x2000 written; second event dropped, oEncErr pulses once, oErrCnt=1. With TRACE_JUMP_FILTER_EN: nothing written, oErrCnt=1.
- Call k=32 (0x10F8, legal), then call k=33 (0x1100 > END) and k=0 -> 0x10F8 written; two errors, oErrCnt=2.
- Hold iFifo_Full=1 and offer 6 calls k=1..6 -> 5 accepted (4 buffered plus the stage), Ready low. Release Full -> 0x1000, 0x1008, 0x1010, 0x1018, 0x1020, 0x1028 written in order, one per clock.
- Assert iRst with 3 words pending -> oFifo_WrEn=0 on the same cycle, no pending words are emitted after release, and Ready=1 one cycle after release.
- Force 2^16+2 illegal events -> oErrCnt saturates at 0xFFFF; oEncErr still pulses for each event.
